// File: rtl/reaction_timer_ctrl.sv
// Reaction-time game controller: random pre-stimulus delay, lamp, then measures the
// player's response in ms (0..999) with false-start detection and a 999 ms timeout.
module reaction_timer_ctrl #(
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned MIN_DELAY_MS = 1000,
    parameter logic [9:0]  RAND_MASK    = 10'h3FF
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Start,
    input  logic       Stop,
    output logic [9:0] Binary,
    output logic       Valid,
    output logic       Led,
    output logic       Busy,
    output logic       FalseStart
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [9:0] MS_MAX = 10'd999;

    typedef enum logic [2:0] {StIdle, StDelay, StTiming, StDone, StEarly} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   delay_q, delay_d;
    logic [9:0]    ms_q, ms_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [9:0]    binary_q, binary_d;
    logic          valid_q, valid_d;
    logic          led_q, led_d;
    logic          busy_q, busy_d;
    logic          fs_q, fs_d;

    logic        tick;
    logic        lfsr_fb;
    logic [15:0] delay_load;

    assign tick       = (presc_q == PRESC_MAX);
    assign lfsr_fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign delay_load = 16'(MIN_DELAY_MS) + {6'd0, lfsr_q[9:0] & RAND_MASK};

    always_comb begin
        state_d  = state_q;
        presc_d  = tick ? '0 : presc_q + PW'(1);
        delay_d  = delay_q;
        ms_d     = ms_q;
        lfsr_d   = {lfsr_q[14:0], lfsr_fb};
        binary_d = binary_q;
        valid_d  = 1'b0;
        led_d    = led_q;
        busy_d   = busy_q;
        fs_d     = fs_q;

        unique case (state_q)
            StIdle, StDone, StEarly: begin
                // Stop is ignored here, so Start alone decides
                if (Start) begin
                    state_d = StDelay;
                    delay_d = delay_load;
                    presc_d = '0;
                    busy_d  = 1'b1;
                    led_d   = 1'b0;
                    fs_d    = 1'b0;
                end
            end
            StDelay: begin
                if (Stop) begin
                    state_d = StEarly;
                    busy_d  = 1'b0;
                    fs_d    = 1'b1;
                end else if (tick) begin
                    if (delay_q <= 16'd1) begin
                        state_d = StTiming;
                        led_d   = 1'b1;
                        ms_d    = '0;
                        presc_d = '0;
                    end else begin
                        delay_d = delay_q - 16'd1;
                    end
                end
            end
            StTiming: begin
                if (Stop) begin
                    state_d  = StDone;
                    binary_d = ms_q;
                    valid_d  = 1'b1;
                    led_d    = 1'b0;
                    busy_d   = 1'b0;
                end else if (tick) begin
                    if (ms_q == MS_MAX) begin
                        state_d  = StDone;
                        binary_d = MS_MAX;
                        valid_d  = 1'b1;
                        led_d    = 1'b0;
                        busy_d   = 1'b0;
                    end else begin
                        ms_d = ms_q + 10'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q  <= StIdle;
            presc_q  <= '0;
            delay_q  <= '0;
            ms_q     <= '0;
            lfsr_q   <= 16'hACE1;
            binary_q <= '0;
            valid_q  <= 1'b0;
            led_q    <= 1'b0;
            busy_q   <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            delay_q  <= delay_d;
            ms_q     <= ms_d;
            lfsr_q   <= lfsr_d;
            binary_q <= binary_d;
            valid_q  <= valid_d;
            led_q    <= led_d;
            busy_q   <= busy_d;
            fs_q     <= fs_d;
        end
    end

    assign Binary     = binary_q;
    assign Valid      = valid_q;
    assign Led        = led_q;
    assign Busy       = busy_q;
    assign FalseStart = fs_q;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Directed bench for reaction_timer_ctrl with a 4-cycle tick, 2 ms fixed delay, no random part.
module tb_reaction_timer_ctrl;

    logic       Clk;
    logic       Rst_n;
    logic       Start;
    logic       Stop;
    logic [9:0] Binary;
    logic       Valid;
    logic       Led;
    logic       Busy;
    logic       FalseStart;

    int total = 0;
    int bad   = 0;

    reaction_timer_ctrl #(
        .TICK_DIV    (4),
        .MIN_DELAY_MS(2),
        .RAND_MASK   (10'h000)
    ) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Start     (Start),
        .Stop      (Stop),
        .Binary    (Binary),
        .Valid     (Valid),
        .Led       (Led),
        .Busy      (Busy),
        .FalseStart(FalseStart)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Outputs are sampled 1 time unit after the edge; inputs change there too.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    task automatic pulse_stop();
        Stop = 1'b1;
        step();
        Stop = 1'b0;
    endtask

    // Steps until Led rises; returns the number of steps taken, or -1 if the bound expires.
    task automatic wait_led(input int bound, output int n);
        n = 0;
        while (Led !== 1'b1 && n < bound) begin
            step();
            n++;
        end
        if (Led !== 1'b1) n = -1;
    endtask

    int n;
    int seen_led;
    int seen_valid;

    initial begin
        Rst_n = 1'b0;
        Start = 1'b1;
        Stop  = 1'b1;
        step();
        step();
        check("rst_binary", Binary, 0);
        check("rst_valid", Valid, 0);
        check("rst_led", Led, 0);
        check("rst_busy", Busy, 0);
        check("rst_falsestart", FalseStart, 0);
        Rst_n = 1'b1;
        Start = 1'b0;
        Stop  = 1'b0;
        step();

        // Normal round: Led 8 cycles after Start, Stop 20 cycles after Led -> 5 ms
        pulse_start();
        check("start_busy", Busy, 1);
        check("start_led_low", Led, 0);
        wait_led(50, n);
        check("led_latency", n, 8);
        repeat (20) step();
        pulse_stop();
        check("round1_binary", Binary, 5);
        check("round1_valid", Valid, 1);
        check("round1_led", Led, 0);
        check("round1_busy", Busy, 0);
        step();
        check("round1_valid_drop", Valid, 0);

        // False start: Stop 3 cycles after Start
        pulse_start();
        check("fs_start_busy", Busy, 1);
        step();
        step();
        pulse_stop();
        check("fs_flag", FalseStart, 1);
        check("fs_busy", Busy, 0);
        check("fs_valid", Valid, 0);
        seen_led   = 0;
        seen_valid = 0;
        repeat (20) begin
            if (Led === 1'b1) seen_led++;
            if (Valid === 1'b1) seen_valid++;
            step();
        end
        check("fs_led_never", seen_led, 0);
        check("fs_valid_never", seen_valid, 0);
        check("fs_binary_held", Binary, 5);
        pulse_start();
        check("fs_cleared", FalseStart, 0);
        check("fs_restart_busy", Busy, 1);

        // Stop on the expiring delay tick (8th edge after Start) still gives EARLY
        repeat (7) step();
        pulse_stop();
        check("expire_early_fs", FalseStart, 1);
        check("expire_early_led", Led, 0);
        check("expire_early_valid", Valid, 0);

        // Stop coincident with the 7th tick in TIMING -> 6
        pulse_start();
        wait_led(50, n);
        check("r37_led_latency", n, 8);
        repeat (27) step();
        pulse_stop();
        check("tick7_binary", Binary, 6);
        check("tick7_valid", Valid, 1);

        // Start+Stop together in DONE: Start wins
        Start = 1'b1;
        Stop  = 1'b1;
        step();
        Start = 1'b0;
        Stop  = 1'b0;
        check("both_busy", Busy, 1);
        check("both_valid", Valid, 0);
        check("both_binary", Binary, 6);

        // Start in DELAY must not reload the delay: Led still 8 edges after the first Start
        step();
        pulse_start();
        wait_led(50, n);
        check("delay_start_ignored", n, 6);

        // Start in TIMING ignored
        pulse_start();
        check("timing_start_led", Led, 1);
        check("timing_start_busy", Busy, 1);

        // Reset mid-TIMING overrides Start/Stop
        Rst_n = 1'b0;
        Start = 1'b1;
        Stop  = 1'b1;
        step();
        check("midrst_binary", Binary, 0);
        check("midrst_led", Led, 0);
        check("midrst_busy", Busy, 0);
        check("midrst_valid", Valid, 0);
        Rst_n = 1'b1;
        Start = 1'b0;
        Stop  = 1'b0;
        step();
        pulse_start();
        wait_led(50, n);
        check("post_rst_led_latency", n, 8);
        repeat (20) step();
        pulse_stop();
        check("post_rst_binary", Binary, 5);
        check("post_rst_valid", Valid, 1);

        // Timeout: no Stop -> 999 with one Valid
        pulse_start();
        wait_led(50, n);
        check("to_led_latency", n, 8);
        n = 0;
        while (Valid !== 1'b1 && n < 5000) begin
            step();
            n++;
        end
        check("timeout_valid", Valid, 1);
        check("timeout_latency_window", (n >= 3996 && n <= 4000) ? 1 : 0, 1);
        check("timeout_binary", Binary, 999);
        check("timeout_led", Led, 0);
        check("timeout_busy", Busy, 0);
        step();
        check("timeout_valid_drop", Valid, 0);

        // Stop in DONE ignored
        pulse_stop();
        check("done_stop_valid", Valid, 0);
        check("done_stop_binary", Binary, 999);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
